eth_rx: RTL

ETH_RX -- requirements
Module: eth_rx

---
 rtl/eth_pkg.sv | 18 +
 rtl/eth_crc32.sv | 25 ++
 rtl/eth_rx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared 10BASE-T receive definitions: CRC-32 constants, framing limits, FSM states.
package eth_pkg;
   localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;

   localparam logic [7:0]  SFD               = 8'hD5;
   localparam int          MIN_PREAMBLE_BITS = 8;

   localparam int          MIN_FRAME = 64;
   localparam int          MAX_FRAME = 1518;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2
   } rx_state_e;
endpackage

// File: rtl/eth_crc32.sv
// Bit-serial Ethernet CRC-32, MSB-first register; bits fed in wire order.
module eth_crc32
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic        bit_in,
   output logic [31:0] crc
);

   logic fb;
   assign fb = bit_in ^ crc[31];

   always_ff @(posedge clk) begin
      if (rst)
         crc <= '0;
      else if (init)
         crc <= CRC_INIT;
      else if (en)
         crc <= {crc[30:0], 1'b0} ^ ({32{fb}} & CRC_POLY);
   end

endmodule

// File: rtl/eth_rx.sv
// 10BASE-T Manchester receiver: oversampled edge recovery, preamble/SFD hunt,
// byte assembly, FCS residue check and frame length/alignment checks.
module eth_rx
   import eth_pkg::*;
#(
   parameter int OVS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sof,
   output logic        rx_eof,
   output logic        rx_crc_ok,
   output logic        rx_err,
   output logic [10:0] rx_bytes
);

   localparam int             TW    = $clog2(3*OVS/2 + 1);
   localparam logic [TW-1:0]  T_ACC = TW'(3*OVS/4);
   localparam logic [TW-1:0]  T_TMO = TW'(3*OVS/2);

   rx_state_e     state;
   logic [2:0]    sync;
   logic [TW-1:0] timer;
   logic          prev_bit;
   logic [3:0]    alt_cnt;
   logic [6:0]    pre_sr;
   logic [6:0]    shreg;
   logic [2:0]    bit_cnt;
   logic [10:0]   byte_cnt;
   logic          first;
   logic [31:0]   crc;

   logic lvl, edge_det, timeout, take, sfd_ok, crc_en;

   // sync[1] is the synchronized level, sync[2] its previous value
   assign lvl      = sync[1];
   assign edge_det = sync[1] ^ sync[2];
   assign timeout  = (state != ST_IDLE) && (timer >= T_TMO);
   // A boundary edge arrives half a bit after the last mid-bit edge and is skipped.
   assign take     = edge_det && !timeout && ((state == ST_IDLE) || (timer >= T_ACC));
   assign sfd_ok   = take && (state == ST_PREAMBLE) && lvl && prev_bit &&
                     (alt_cnt >= 4'(MIN_PREAMBLE_BITS)) && ({lvl, pre_sr} == SFD);
   assign crc_en   = take && (state == ST_DATA);

   eth_crc32 u_crc (
      .clk    (clk),
      .rst    (rst),
      .init   (sfd_ok),
      .en     (crc_en),
      .bit_in (lvl),
      .crc    (crc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sync      <= '0;
         timer     <= '0;
         prev_bit  <= 1'b0;
         alt_cnt   <= '0;
         pre_sr    <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         first     <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_sof    <= 1'b0;
         rx_eof    <= 1'b0;
         rx_crc_ok <= 1'b0;
         rx_err    <= 1'b0;
         rx_bytes  <= '0;
      end else begin
         sync     <= {sync[1:0], rx};
         rx_valid <= 1'b0;
         rx_sof   <= 1'b0;
         rx_eof   <= 1'b0;

         if (take)
            timer <= '0;
         else if (timer != '1)
            timer <= timer + 1'b1;

         case (state)
            ST_IDLE: begin
               if (take) begin
                  state    <= ST_PREAMBLE;
                  prev_bit <= lvl;
                  alt_cnt  <= 4'd1;
                  pre_sr   <= {lvl, 6'b0};
               end
            end

            ST_PREAMBLE: begin
               if (timeout) begin
                  state <= ST_IDLE;
               end else if (take) begin
                  prev_bit <= lvl;
                  pre_sr   <= {lvl, pre_sr[6:1]};
                  if (lvl != prev_bit) begin
                     if (alt_cnt != 4'hF)
                        alt_cnt <= alt_cnt + 1'b1;
                  end else if (sfd_ok) begin
                     state    <= ST_DATA;
                     bit_cnt  <= '0;
                     byte_cnt <= '0;
                     first    <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end

            ST_DATA: begin
               if (timeout) begin
                  // Loss of carrier closes the frame; a partial byte is dropped.
                  state     <= ST_IDLE;
                  rx_eof    <= 1'b1;
                  rx_crc_ok <= (crc == CRC_RESIDUE);
                  rx_err    <= (bit_cnt != 3'd0) ||
                               (byte_cnt < 11'(MIN_FRAME)) ||
                               (byte_cnt > 11'(MAX_FRAME));
                  rx_bytes  <= byte_cnt;
               end else if (take) begin
                  shreg   <= {lvl, shreg[6:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     rx_data  <= {lvl, shreg};
                     rx_valid <= 1'b1;
                     rx_sof   <= first;
                     first    <= 1'b0;
                     if (byte_cnt != 11'h7FF)
                        byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
